// File: rtl/led_mon_pkg.sv
// Shared mode encodings and the PWM breathing helper for the LED activity monitor.
package led_mon_pkg;

    typedef enum logic [1:0] {
        MODE_BIN    = 2'd0,
        MODE_WALK   = 2'd1,
        MODE_PWM    = 2'd2,
        MODE_FREEZE = 2'd3
    } mode_e;

    localparam int PWM_W = 8;

    // Triangle ramp: the brightness rises over the first half of the period and falls over the second.
    function automatic logic [PWM_W-1:0] breath_level(input logic [PWM_W:0] t);
        return t[PWM_W] ? ~t[PWM_W-1:0] : t[PWM_W-1:0];
    endfunction

endpackage

// File: rtl/act_stretcher.sv
// One activity channel: a retriggerable down-counter that keeps its LED lit
// for 2^STRETCH_W-1 cycles after the last event strobe.
module act_stretcher #(
    parameter int STRETCH_W  = 22,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pulse_i,
    output logic led_o
);

    localparam logic [STRETCH_W-1:0] S_ONE = 1;

    logic [STRETCH_W-1:0] s_q, s_d;

    always_comb begin
        // NOTE: every combinational output gets a value before any branch, so no path can infer a latch.
        s_d = s_q;
        if (pulse_i) begin
            s_d = '1;
        end else if (s_q != '0) begin
            s_d = s_q - S_ONE;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

    assign led_o = (s_q != '0) ^ ACTIVE_LOW;

endmodule

// File: rtl/led_activity_monitor.sv
// Free-running counter driving a selectable display pattern plus a bank of
// stretched activity LEDs, all in the monitored clock domain.
module led_activity_monitor
    import led_mon_pkg::*;
#(
    parameter int CNT_W      = 30,
    parameter int DISP_W     = 4,
    parameter int NUM_ACT    = 4,
    parameter int STRETCH_W  = 22,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               clear,
    input  logic [1:0]         mode,
    input  logic [NUM_ACT-1:0] act_pulse,
    output logic [DISP_W-1:0]  disp,
    output logic [NUM_ACT-1:0] act_led,
    output logic               tick
);

    localparam int IDX_W = (DISP_W > 1) ? $clog2(DISP_W) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic [DISP_W-1:0] pat_q, pat_d;

    mode_e             mode_sel;
    logic [IDX_W-1:0]  walk_idx;
    logic [DISP_W-1:0] walk_pat;
    logic [PWM_W:0]    pwm_t;
    logic              pwm_on;

    assign mode_sel = mode_e'(mode);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Only a real increment out of all-ones counts as a wrap; a clear never ticks.
    assign tick_d = enable & ~clear & (&cnt_q);

    assign walk_idx = cnt_q[CNT_W-1 -: IDX_W];

    always_comb begin
        walk_pat = '0;
        for (int i = 0; i < DISP_W; i++) begin
            walk_pat[i] = (DISP_W == 1) || (walk_idx == IDX_W'(i));
        end
    end

    assign pwm_t  = cnt_q[CNT_W-1 -: PWM_W+1];
    assign pwm_on = cnt_q[PWM_W-1:0] < breath_level(pwm_t);

    always_comb begin
        pat_d = pat_q;
        case (mode_sel)
            MODE_BIN:    pat_d = cnt_q[CNT_W-1 -: DISP_W];
            MODE_WALK:   pat_d = walk_pat;
            MODE_PWM:    pat_d = {DISP_W{pwm_on}};
            MODE_FREEZE: pat_d = pat_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            pat_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            pat_q  <= pat_d;
        end
    end

    assign disp = pat_q ^ {DISP_W{ACTIVE_LOW}};
    assign tick = tick_q;

    for (genvar g = 0; g < NUM_ACT; g++) begin : g_act
        act_stretcher #(
            .STRETCH_W  (STRETCH_W),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_stretch (
            .clk     (clk),
            .reset_n (reset_n),
            .pulse_i (act_pulse[g]),
            .led_o   (act_led[g])
        );
    end

endmodule

// File: tb/tb_led_activity_monitor.sv
// Scoreboard bench: the driver models each cycle and queues the expected outputs,
// the monitor pops one entry per clock edge (and per reset assertion) and compares.
module tb_led_activity_monitor;
    import led_mon_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       clear;
    logic [1:0] mode;
    logic [3:0] act_pulse;
    logic [3:0] disp;
    logic [3:0] act_led;
    logic       tick;

    led_activity_monitor #(
        .CNT_W      (18),
        .DISP_W     (4),
        .NUM_ACT    (4),
        .STRETCH_W  (4),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .clear     (clear),
        .mode      (mode),
        .act_pulse (act_pulse),
        .disp      (disp),
        .act_led   (act_led),
        .tick      (tick)
    );

    typedef struct packed {
        logic [31:0] idx;
        logic [3:0]  disp;
        logic [3:0]  led;
        logic        tick;
        logic [17:0] cnt;
        logic        hd_en;
        logic [3:0]  hd;
        logic        hl_en;
        logic [3:0]  hl;
    } exp_t;

    exp_t sb_q[$];

    int checks     = 0;
    int failures   = 0;
    int tick_seen  = 0;
    int step_no    = 0;
    bit run_active = 0;

    logic [17:0] m_cnt;
    logic [3:0]  m_pat;
    logic        m_tick;
    logic [3:0]  m_s [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp, input int idx);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, act, exp);
            if (failures >= 30) summary();
        end
    endtask

    function automatic logic [3:0] model_pat(input logic [17:0] c, input logic [1:0] md, input logic [3:0] prev);
        logic [8:0] t;
        logic [7:0] b;
        t = c[17:9];
        b = t[8] ? ~t[7:0] : t[7:0];
        case (md)
            2'd0:    return c[17:14];
            2'd1:    return 4'b0001 << c[17:16];
            2'd2:    return (c[7:0] < b) ? 4'hF : 4'h0;
            default: return prev;
        endcase
    endfunction

    function automatic logic [3:0] model_led();
        logic [3:0] l;
        for (int i = 0; i < 4; i++) l[i] = (m_s[i] == 4'h0);
        return l;
    endfunction

    task automatic model_reset();
        m_cnt  = '0;
        m_pat  = '0;
        m_tick = 1'b0;
        for (int i = 0; i < 4; i++) m_s[i] = 4'h0;
    endtask

    task automatic push(input logic hd_en, input logic [3:0] hd, input logic hl_en, input logic [3:0] hl);
        exp_t e;
        e.idx   = step_no;
        e.disp  = ~m_pat;
        e.led   = model_led();
        e.tick  = m_tick;
        e.cnt   = m_cnt;
        e.hd_en = hd_en;
        e.hd    = hd;
        e.hl_en = hl_en;
        e.hl    = hl;
        sb_q.push_back(e);
        step_no++;
    endtask

    task automatic step(input logic en, input logic clr, input logic [1:0] md, input logic [3:0] pulse,
                        input logic rst_low, input logic hd_en, input logic [3:0] hd,
                        input logic hl_en, input logic [3:0] hl);
        @(negedge clk);
        enable    = en;
        clear     = clr;
        mode      = md;
        act_pulse = pulse;
        reset_n   = ~rst_low;
        if (rst_low) begin
            model_reset();
        end else begin
            m_tick = en && !clr && (m_cnt == 18'h3FFFF);
            m_pat  = model_pat(m_cnt, md, m_pat);
            m_cnt  = clr ? 18'h0 : (en ? m_cnt + 18'h1 : m_cnt);
            for (int i = 0; i < 4; i++)
                m_s[i] = pulse[i] ? 4'hF : ((m_s[i] != 4'h0) ? m_s[i] - 4'h1 : 4'h0);
        end
        push(hd_en, hd, hl_en, hl);
        run_active = 1;
    endtask

    task automatic go(input logic [1:0] md);
        step(1'b1, 1'b0, md, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    endtask

    task automatic go_disp(input logic [1:0] md, input logic [3:0] hd);
        step(1'b1, 1'b0, md, 4'h0, 1'b0, 1'b1, hd, 1'b0, 4'h0);
    endtask

    task automatic go_led(input logic [3:0] pulse, input logic [3:0] hl);
        step(1'b1, 1'b0, MODE_BIN, pulse, 1'b0, 1'b0, 4'h0, 1'b1, hl);
    endtask

    task automatic run_until(input logic [17:0] target);
        while (m_cnt != target) go(MODE_BIN);
    endtask

    // Monitor: one scoreboard entry per clock edge, plus one per asynchronous reset assertion.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge reset_n);
            #1;
            if (sb_q.size() == 0) begin
                if (run_active) check("scoreboard_empty", 32'd1, 32'd0, step_no);
            end else begin
                e = sb_q.pop_front();
                if (tick === 1'b1) tick_seen++;
                check("disp", {28'h0, disp}, {28'h0, e.disp}, e.idx);
                check("act_led", {28'h0, act_led}, {28'h0, e.led}, e.idx);
                check("tick", {31'h0, tick}, {31'h0, e.tick}, e.idx);
                check("cnt", {14'h0, dut.cnt_q}, {14'h0, e.cnt}, e.idx);
                if (e.hd_en) check("disp_hand", {28'h0, disp}, {28'h0, e.hd}, e.idx);
                if (e.hl_en) check("led_hand", {28'h0, act_led}, {28'h0, e.hl}, e.idx);
            end
        end
    end

    initial begin
        reset_n   = 1'b1;
        enable    = 1'b0;
        clear     = 1'b0;
        mode      = 2'd0;
        act_pulse = 4'h0;
        model_reset();

        #1;
        push(1'b1, 4'b1111, 1'b1, 4'b1111);
        reset_n = 1'b0;
        repeat (2) step(1'b0, 1'b0, MODE_BIN, 4'h0, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b1111);
        go_disp(MODE_BIN, 4'b1111);

        // Single pulse: 15 lit cycles on channel 0 only.
        run_until(18'd16);
        go_led(4'b0001, 4'b1110);
        repeat (14) go_led(4'b0000, 4'b1110);
        go_led(4'b0000, 4'b1111);

        // Retrigger during lit cycle 10: 25 lit cycles in total.
        run_until(18'd64);
        go_led(4'b0001, 4'b1110);
        repeat (9) go_led(4'b0000, 4'b1110);
        go_led(4'b0001, 4'b1110);
        repeat (14) go_led(4'b0000, 4'b1110);
        go_led(4'b0000, 4'b1111);

        // Held pulse on channel 2 for 5 cycles, then the stretch tail.
        run_until(18'd128);
        repeat (5) go_led(4'b0100, 4'b1011);
        repeat (14) go_led(4'b0000, 4'b1011);
        go_led(4'b0000, 4'b1111);

        run_until(18'h04010);
        go_disp(MODE_PWM, 4'b0000);
        run_until(18'h04080);
        go_disp(MODE_PWM, 4'b1111);

        run_until(18'h0C000);
        go_disp(MODE_BIN, 4'b1100);
        repeat (5000) go_disp(MODE_FREEZE, 4'b1100);
        go_disp(MODE_BIN, 4'b1100);

        run_until(18'h10000);
        go_disp(MODE_WALK, 4'b1101);

        // Freeze across a change of the top bits.
        run_until(18'h1BFFE);
        go_disp(MODE_BIN, 4'b1001);
        repeat (4) go_disp(MODE_FREEZE, 4'b1001);
        go_disp(MODE_BIN, 4'b1000);

        run_until(18'h20000);
        go_disp(MODE_WALK, 4'b1011);

        run_until(18'h2A010);
        go_disp(MODE_PWM, 4'b0000);
        run_until(18'h2A0C0);
        go_disp(MODE_PWM, 4'b1111);

        run_until(18'h2ABCD);
        step(1'b1, 1'b1, MODE_BIN, 4'h0, 1'b0, 1'b1, 4'b0101, 1'b0, 4'h0);
        repeat (100) step(1'b0, 1'b0, MODE_BIN, 4'h0, 1'b0, 1'b1, 4'b1111, 1'b0, 4'h0);

        // Asynchronous reset with channel 1 lit at cnt 0x01234.
        run_until(18'h01230);
        go_led(4'b0010, 4'b1101);
        repeat (3) go_led(4'b0000, 4'b1101);
        @(posedge clk);
        #3;
        model_reset();
        push(1'b1, 4'b1111, 1'b1, 4'b1111);
        reset_n = 1'b0;
        step(1'b1, 1'b0, MODE_BIN, 4'h0, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b1111);

        // Free run from release across the full 2^18 wrap.
        go_disp(MODE_BIN, 4'b1111);
        for (int i = 1; i < (1 << 18) + 2; i++) begin
            if (m_cnt == 18'h30000) go_disp(MODE_WALK, 4'b0111);
            else go(MODE_BIN);
        end

        @(posedge clk);
        #2;
        run_active = 0;
        check("tick_count", tick_seen, 32'd1, step_no);
        summary();
    end

endmodule
